// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus decoder and ROB
// redirect signals. The fetch unit uses the master view; memory, decoder and ROB use the slave view.
interface ifetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        inst_valid;
  logic [31:0] PC;
  logic [31:0] inst_out;
  logic        need_inst;
  logic        clear_inst;
  logic [31:0] if_addr;
  logic        rob_clear;
  logic [31:0] rob_new_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, PC, inst_out,
    input  mem_ready, mem_data, need_inst, clear_inst, if_addr, rob_clear, rob_new_pc
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, PC, inst_out,
    output mem_ready, mem_data, need_inst, clear_inst, if_addr, rob_clear, rob_new_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: one outstanding word read, a small {pc, inst} FIFO toward the
// decoder, and restart on decoder/ROB redirects with in-flight responses discarded.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  ifetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_mem_req;
  logic             w_mem_req_nxt;
  logic [31:0]      r_mem_addr;
  logic [31:0]      w_mem_addr_nxt;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      w_fetch_pc_nxt;
  logic [31:0]      w_pc_inc;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [31:0]      r_pc_q   [QUEUE_DEPTH];
  logic [31:0]      r_inst_q [QUEUE_DEPTH];
  logic             w_valid;
  logic             w_redirect;
  logic [31:0]      w_target_raw;
  logic [31:0]      w_target;
  logic             w_enq;
  logic             w_deq;
  logic             w_credit;

  // ROB flush outranks the decoder redirect; targets are forced word-aligned.
  assign w_redirect   = rdy & (bus.rob_clear | bus.clear_inst);
  assign w_target_raw = bus.rob_clear ? bus.rob_new_pc : bus.if_addr;
  assign w_target     = w_target_raw & 32'hFFFF_FFFC;
  assign w_pc_inc     = r_fetch_pc + 32'd4;

  assign w_valid = (r_count != {CNT_W{1'b0}});
  assign w_enq   = rdy & bus.mem_ready & (r_state == ST_WAIT) & ~w_redirect;
  assign w_deq   = rdy & w_valid & ~bus.need_inst & ~w_redirect;

  // FIFO occupancy after this cycle's flush, enqueue and dequeue.
  always_comb begin
    w_count_nxt = r_count;
    if (w_redirect) begin
      w_count_nxt = {CNT_W{1'b0}};
    end else begin
      case ({w_enq, w_deq})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Nothing is outstanding once a response lands, so credit depends only on the next count.
  assign w_credit = (w_count_nxt < DEPTH_C);

  assign bus.inst_valid = w_valid;
  assign bus.PC         = w_valid ? r_pc_q[r_head]   : 32'h0;
  assign bus.inst_out   = w_valid ? r_inst_q[r_head] : 32'h0;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;

  // Fetch FSM next-state, request and fetch-pc logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_fetch_pc_nxt = r_fetch_pc;
    if (!rdy) begin
      w_state_nxt = r_state;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_redirect) begin
            w_fetch_pc_nxt = w_target;
          end else if (w_credit) begin
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = r_fetch_pc;
            w_state_nxt    = ST_WAIT;
          end else begin
            w_mem_req_nxt = 1'b0;
          end
        end
        ST_WAIT: begin
          if (w_redirect) begin
            w_fetch_pc_nxt = w_target;
            if (bus.mem_ready) begin
              w_mem_req_nxt = 1'b0;
              w_state_nxt   = ST_IDLE;
            end else begin
              w_state_nxt = ST_DROP;
            end
          end else if (bus.mem_ready) begin
            w_fetch_pc_nxt = w_pc_inc;
            if (w_credit) begin
              w_mem_addr_nxt = w_pc_inc;
            end else begin
              w_mem_req_nxt = 1'b0;
              w_state_nxt   = ST_IDLE;
            end
          end else begin
            w_mem_req_nxt = 1'b1;
          end
        end
        ST_DROP: begin
          if (w_redirect) begin
            w_fetch_pc_nxt = w_target;
          end else begin
            w_fetch_pc_nxt = r_fetch_pc;
          end
          // The arriving response belongs to the abandoned path and is thrown away.
          if (bus.mem_ready) begin
            w_mem_req_nxt = 1'b0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_mem_req_nxt = 1'b1;
          end
        end
        default: begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end
      endcase
    end
  end

  // Fetch FSM state, request and fetch-pc registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (w_redirect) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_head  <= w_deq ? r_head + PTR_W'(1) : r_head;
      r_tail  <= w_enq ? r_tail + PTR_W'(1) : r_tail;
      r_count <= w_count_nxt;
    end
  end

  // FIFO storage; head outputs are masked while empty so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_q[r_tail]   <= r_fetch_pc;
      r_inst_q[r_tail] <= bus.mem_data;
    end else begin
      r_pc_q[r_tail]   <= r_pc_q[r_tail];
      r_inst_q[r_tail] <= r_inst_q[r_tail];
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: streaming, backpressure, redirects, rdy stall and async reset,
// against a latency-programmable memory returning addr+0x100.
module tb_ifetch_queue;
  logic clk;
  logic rst;
  logic rdy;
  logic force_ready;
  int   mem_lat;
  int   mem_cnt;
  int   total;
  int   bad;

  ifetch_queue_if bus ();

  ifetch_queue #(
    .RESET_PC    (32'h0),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: responds in the mem_lat-th cycle a request is presented; force_ready injects a stray pulse.
  assign bus.mem_ready = (rdy && bus.mem_req && (mem_cnt == mem_lat - 1)) || force_ready;
  assign bus.mem_data  = bus.mem_addr + 32'h100;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_cnt <= 0;
    end else if (rdy) begin
      if (!bus.mem_req || bus.mem_ready) mem_cnt <= 0;
      else mem_cnt <= mem_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rdy = 1'b1;
    force_ready = 1'b0;
    mem_lat = 1;
    bus.need_inst = 1'b0;
    bus.clear_inst = 1'b0;
    bus.if_addr = 32'h0;
    bus.rob_clear = 1'b0;
    bus.rob_new_pc = 32'h0;
    rst = 1'b0;
    #1;
    check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_valid", {31'h0, bus.inst_valid}, 32'h0);
    check("rst_pc", bus.PC, 32'h0);
    check("rst_inst", bus.inst_out, 32'h0);

    // Streaming with 1-cycle memory, decoder always consuming.
    do_reset();
    step(1);
    check("s_first_req", {31'h0, bus.mem_req}, 32'h1);
    check("s_first_addr", bus.mem_addr, 32'h0);
    check("s_first_valid", {31'h0, bus.inst_valid}, 32'h0);
    step(1);
    check("s_valid0", {31'h0, bus.inst_valid}, 32'h1);
    check("s_pc0", bus.PC, 32'h0);
    check("s_inst0", bus.inst_out, 32'h100);
    check("s_addr0", bus.mem_addr, 32'h4);
    for (int k = 1; k < 4; k++) begin
      step(1);
      check("s_pc", bus.PC, 32'(4 * k));
      check("s_inst", bus.inst_out, 32'h100 + 32'(4 * k));
      check("s_addr", bus.mem_addr, 32'(4 * k + 4));
    end

    // Backpressure: four entries fill the queue, then one dequeue frees a credit.
    bus.need_inst = 1'b1;
    do_reset();
    step(5);
    check("bp_req_drop", {31'h0, bus.mem_req}, 32'h0);
    check("bp_head", bus.PC, 32'h0);
    step(1);
    check("bp_req_idle", {31'h0, bus.mem_req}, 32'h0);
    bus.need_inst = 1'b0;
    step(1);
    bus.need_inst = 1'b1;
    check("bp_head_next", bus.PC, 32'h4);
    check("bp_inst_next", bus.inst_out, 32'h104);
    check("bp_req_again", {31'h0, bus.mem_req}, 32'h1);
    check("bp_addr16", bus.mem_addr, 32'h10);

    // Decoder redirect while waiting on a 3-cycle read of 8.
    mem_lat = 3;
    do_reset();
    step(7);
    check("dr_wait8", bus.mem_addr, 32'h8);
    bus.clear_inst = 1'b1;
    bus.if_addr = 32'h40;
    step(1);
    bus.clear_inst = 1'b0;
    check("dr_flush", {31'h0, bus.inst_valid}, 32'h0);
    check("dr_drop_req", {31'h0, bus.mem_req}, 32'h1);
    check("dr_drop_addr", bus.mem_addr, 32'h8);
    step(1);
    check("dr_drop_hold", {31'h0, bus.mem_req}, 32'h1);
    step(1);
    check("dr_idle_req", {31'h0, bus.mem_req}, 32'h0);
    check("dr_discard", {31'h0, bus.inst_valid}, 32'h0);
    step(1);
    check("dr_new_req", {31'h0, bus.mem_req}, 32'h1);
    check("dr_new_addr", bus.mem_addr, 32'h40);
    step(3);
    check("dr_tgt_valid", {31'h0, bus.inst_valid}, 32'h1);
    check("dr_tgt_pc", bus.PC, 32'h40);
    check("dr_tgt_inst", bus.inst_out, 32'h140);
    check("dr_next_addr", bus.mem_addr, 32'h44);

    // ROB and decoder redirect together, coinciding with a response.
    step(2);
    bus.rob_clear = 1'b1;
    bus.rob_new_pc = 32'h83;
    bus.clear_inst = 1'b1;
    bus.if_addr = 32'h40;
    step(1);
    bus.rob_clear = 1'b0;
    bus.clear_inst = 1'b0;
    check("rb_flush", {31'h0, bus.inst_valid}, 32'h0);
    check("rb_idle", {31'h0, bus.mem_req}, 32'h0);
    step(1);
    check("rb_req", {31'h0, bus.mem_req}, 32'h1);
    check("rb_addr", bus.mem_addr, 32'h80);

    // rdy low for five cycles with a stray response pulse.
    rdy = 1'b0;
    step(2);
    force_ready = 1'b1;
    step(1);
    force_ready = 1'b0;
    check("st_no_enq", {31'h0, bus.inst_valid}, 32'h0);
    step(2);
    check("st_addr", bus.mem_addr, 32'h80);
    check("st_req", {31'h0, bus.mem_req}, 32'h1);
    check("st_valid", {31'h0, bus.inst_valid}, 32'h0);
    rdy = 1'b1;
    step(1);
    check("st_resume_addr", bus.mem_addr, 32'h80);
    step(2);
    check("st_valid_after", {31'h0, bus.inst_valid}, 32'h1);
    check("st_pc_after", bus.PC, 32'h80);
    check("st_inst_after", bus.inst_out, 32'h180);
    check("st_next_addr", bus.mem_addr, 32'h84);

    // Asynchronous reset mid-wait with three entries buffered.
    step(6);
    check("ar_pre_valid", {31'h0, bus.inst_valid}, 32'h1);
    check("ar_pre_pc", bus.PC, 32'h80);
    check("ar_pre_addr", bus.mem_addr, 32'h8c);
    #2;
    rst = 1'b0;
    #1;
    check("ar_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("ar_mem_addr", bus.mem_addr, 32'h0);
    check("ar_valid", {31'h0, bus.inst_valid}, 32'h0);
    check("ar_pc", bus.PC, 32'h0);
    check("ar_inst", bus.inst_out, 32'h0);
    step(1);
    rst = 1'b1;
    step(1);
    check("ar_restart_req", {31'h0, bus.mem_req}, 32'h1);
    check("ar_restart_addr", bus.mem_addr, 32'h0);
    check("ar_restart_valid", {31'h0, bus.inst_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
